// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-substitution helper.
package aes_pkg;

  localparam int NUM_ROUNDS = 10;

  typedef logic [31:0]     aes_word_t;
  typedef aes_word_t [3:0] aes_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t sub_word(input aes_word_t w);
    aes_word_t r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = AES_SBOX[w[8*b +: 8]];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: RotWord/SubWord/Rcon on w3, then the xor chain.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_key_t   cur_key_i,
  input  logic [3:0] round_i,
  output aes_key_t   next_key_o
);

  logic [7:0] rcon;
  aes_word_t  t;

  // Round indices outside 1..10 never occur in operation; give them a zero Rcon.
  always_comb begin
    rcon = 8'h00;
    if (round_i >= 4'd1 && round_i <= 4'd10) begin
      rcon = RCON[round_i];
    end
  end

  assign t = sub_word({cur_key_i[3][23:0], cur_key_i[3][31:24]}) ^ {rcon, 24'h000000};

  assign next_key_o[0] = cur_key_i[0] ^ t;
  assign next_key_o[1] = cur_key_i[1] ^ next_key_o[0];
  assign next_key_o[2] = cur_key_i[2] ^ next_key_o[1];
  assign next_key_o[3] = cur_key_i[3] ^ next_key_o[2];

endmodule

// File: rtl/aes_key_schedule_unit.sv
// Sequential AES-128 key schedule: one expansion step per clock, all 11 round keys
// held in a register buffer that the round datapath reads by index.
module aes_key_schedule_unit
  import aes_pkg::*;
#(
  parameter int regSize   = 32,
  parameter int vecSize   = 4,
  parameter int numRounds = NUM_ROUNDS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [vecSize-1:0][regSize-1:0] key_in,
  output logic                            busy,
  output logic                            done,
  output logic                            key_valid,
  input  logic [3:0]                      rd_addr,
  output logic [vecSize-1:0][regSize-1:0] rd_key,
  output state_e                          dbg_state_o
);

  state_e     state_q, state_d;
  aes_key_t   cur_key_q, cur_key_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic       key_valid_q, key_valid_d;
  aes_key_t   rk_q [numRounds+1];

  logic       wr_en;
  logic [3:0] wr_idx;
  aes_key_t   wr_data;
  aes_key_t   step_key;

  aes_key_step u_step (
    .cur_key_i  (cur_key_q),
    .round_i    (round_cnt_q),
    .next_key_o (step_key)
  );

  always_comb begin
    state_d     = state_q;
    cur_key_d   = cur_key_q;
    round_cnt_d = round_cnt_q;
    key_valid_d = key_valid_q;
    wr_en       = 1'b0;
    wr_idx      = round_cnt_q;
    wr_data     = step_key;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          wr_en       = 1'b1;
          wr_idx      = 4'd0;
          wr_data     = key_in;
          cur_key_d   = key_in;
          round_cnt_d = 4'd1;
          key_valid_d = 1'b0;
          state_d     = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        wr_en       = 1'b1;
        cur_key_d   = step_key;
        round_cnt_d = round_cnt_q + 4'd1;
        // key_valid rises together with the done pulse.
        if (round_cnt_q == 4'(numRounds)) begin
          state_d     = ST_DONE;
          key_valid_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_key_q   <= '0;
      round_cnt_q <= 4'd0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= numRounds; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cur_key_q   <= cur_key_d;
      round_cnt_q <= round_cnt_d;
      key_valid_q <= key_valid_d;
      if (wr_en) begin
        rk_q[wr_idx] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_key = '0;
    if (rd_addr <= 4'(numRounds)) begin
      rd_key = rk_q[rd_addr];
    end
  end

  assign busy        = (state_q == ST_EXPAND);
  assign done        = (state_q == ST_DONE);
  assign key_valid   = key_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_aes_key_schedule_unit.sv
// Directed bench for aes_key_schedule_unit using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule_unit;
  import aes_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0][31:0] key_in;
  logic             busy;
  logic             done;
  logic             key_valid;
  logic [3:0]       rd_addr;
  logic [3:0][31:0] rd_key;
  state_e           dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done_cnt = 0;

  logic [127:0] exp_q [$];
  logic [3:0]   addr_q [$];

  localparam logic [127:0] ZERO_KEY = 128'h0;
  localparam logic [127:0] FIPS_KEY = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [127:0] FIPS_RK1 = {32'h2a6c7605, 32'h23a33939, 32'h88542cb1, 32'ha0fafe17};
  localparam logic [127:0] FIPS_RK10 = {32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
  localparam logic [127:0] ZERO_RK1 = {4{32'h62636363}};
  localparam logic [127:0] ZERO_RK2 = {32'hf9fbfbaa, 32'h9b9898c9, 32'hf9fbfbaa, 32'h9b9898c9};
  localparam logic [127:0] ZERO_RK10 = {32'h6f8f188e, 32'h23e951cf, 32'h3e92e211, 32'hb4ef5bcb};

  aes_key_schedule_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key_in      (key_in),
    .busy        (busy),
    .done        (done),
    .key_valid   (key_valid),
    .rd_addr     (rd_addr),
    .rd_key      (rd_key),
    .dbg_state_o (dbg_state)
  );

  // Clock and done-pulse monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 128'(done), 128'(1'b1));
  endtask

  // Scoreboard: queue (addr, expected key) pairs, then drain them against the read port.
  task automatic expect_rk(input logic [3:0] a, input logic [127:0] e);
    addr_q.push_back(a);
    exp_q.push_back(e);
  endtask

  task automatic drain_reads(input string tag);
    logic [3:0]   a;
    logic [127:0] e;
    while (exp_q.size() > 0) begin
      a = addr_q.pop_front();
      e = exp_q.pop_front();
      rd_addr = a;
      #1;
      check($sformatf("%s_rk%0d", tag, a), rd_key, e);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    key_in = '0;
    rd_addr = 4'd0;

    // Reset state
    do_reset(3);
    #1;
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_kv", 128'(key_valid), 128'(1'b0));
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    expect_rk(4'd0, ZERO_KEY);
    expect_rk(4'd10, ZERO_KEY);
    drain_reads("rst");

    // Zero key with exact latency: done in the cycle after E10
    pulse_start(ZERO_KEY);
    check("zero_busy_e0", 128'(busy), 128'(1'b1));
    repeat (9) @(negedge clk);
    check("zero_done_e9", 128'(done), 128'(1'b0));
    @(negedge clk);
    check("zero_done_e10", 128'(done), 128'(1'b1));
    check("zero_kv_at_done", 128'(key_valid), 128'(1'b1));
    exp_done_cnt++;
    @(negedge clk);
    check("zero_done_pulse", 128'(done), 128'(1'b0));
    check("zero_busy_after", 128'(busy), 128'(1'b0));
    check("zero_kv_hold", 128'(key_valid), 128'(1'b1));
    expect_rk(4'd0, ZERO_KEY);
    expect_rk(4'd1, ZERO_RK1);
    expect_rk(4'd2, ZERO_RK2);
    expect_rk(4'd10, ZERO_RK10);
    drain_reads("zero");

    // FIPS-197 key
    pulse_start(FIPS_KEY);
    check("fips_kv_drop", 128'(key_valid), 128'(1'b0));
    wait_done("fips_done", 20);
    exp_done_cnt++;
    @(negedge clk);
    expect_rk(4'd0, FIPS_KEY);
    expect_rk(4'd1, FIPS_RK1);
    expect_rk(4'd10, FIPS_RK10);
    drain_reads("fips");

    // Out-of-range reads
    for (int a = 11; a <= 15; a++) expect_rk(4'(a), ZERO_KEY);
    drain_reads("oor");

    // Second start while busy is ignored
    pulse_start(ZERO_KEY);
    repeat (2) @(negedge clk);
    key_in = FIPS_KEY;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("busy_start_busy", 128'(busy), 128'(1'b1));
    wait_done("busy_start_done", 20);
    exp_done_cnt++;
    repeat (20) @(negedge clk);
    check("busy_start_state", 128'(dbg_state), 128'(ST_IDLE));
    check("busy_start_one_done", 128'(done_cnt), 128'(exp_done_cnt));
    expect_rk(4'd0, ZERO_KEY);
    expect_rk(4'd1, ZERO_RK1);
    expect_rk(4'd10, ZERO_RK10);
    drain_reads("busy_start");

    // Reset mid-expansion
    pulse_start(FIPS_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    check("midrst_busy", 128'(busy), 128'(1'b0));
    check("midrst_kv", 128'(key_valid), 128'(1'b0));
    for (int a = 0; a <= 10; a++) expect_rk(4'(a), ZERO_KEY);
    drain_reads("midrst");
    repeat (15) @(negedge clk);
    check("midrst_no_done", 128'(done_cnt), 128'(exp_done_cnt));
    check("midrst_idle", 128'(dbg_state), 128'(ST_IDLE));
    pulse_start(FIPS_KEY);
    wait_done("midrst_restart_done", 20);
    exp_done_cnt++;
    @(negedge clk);
    expect_rk(4'd1, FIPS_RK1);
    expect_rk(4'd10, FIPS_RK10);
    drain_reads("midrst_restart");

    // Back-to-back: start again in the IDLE cycle right after done
    pulse_start(FIPS_KEY);
    wait_done("b2b_first_done", 20);
    exp_done_cnt++;
    @(negedge clk);
    key_in = ZERO_KEY;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    check("b2b_kv_drop", 128'(key_valid), 128'(1'b0));
    check("b2b_busy", 128'(busy), 128'(1'b1));
    wait_done("b2b_second_done", 20);
    exp_done_cnt++;
    @(negedge clk);
    check("b2b_done_count", 128'(done_cnt), 128'(exp_done_cnt));
    expect_rk(4'd0, ZERO_KEY);
    expect_rk(4'd1, ZERO_RK1);
    expect_rk(4'd2, ZERO_RK2);
    expect_rk(4'd10, ZERO_RK10);
    for (int a = 11; a <= 15; a++) expect_rk(4'(a), ZERO_KEY);
    drain_reads("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
